// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {IDLE, XFER} arb_state_t;

    localparam int FRAME_CNT_W = 16;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request bit after last_grant,
// wrapping around, so the most recent owner has the lowest priority.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    pick_id,
    output logic               pick_vld
);

    logic [ID_W-1:0] idx;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        pick_id  = '0;
        pick_vld = 1'b0;
        idx      = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            idx = ID_W'((int'(last_grant) + off) % NUM_REQ);
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Frame-granular round-robin arbiter for the async FIFO write port; holds the
// grant from first beat to accepted last beat and throttles on full.
//
// state | meaning
// IDLE  | no owner; arbitrate among valid requesters
// XFER  | grant_id owns the write port until its last beat is accepted
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      wclk,
    input  logic                      wr_rstn,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      full,
    output logic                      wr_en,
    output logic [DATA_W-1:0]         wr_data,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      frame_done,
    output logic [FRAME_CNT_W-1:0]    frame_cnt
);

    arb_state_t             state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        last_grant_q, last_grant_d;
    logic                   frame_done_q, frame_done_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic [ID_W-1:0]        pick_id;
    logic                   pick_vld;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_picker (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .pick_id    (pick_id),
        .pick_vld   (pick_vld)
    );

    assign wr_data = req_data[grant_q*DATA_W +: DATA_W];

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        req_ready    = '0;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    grant_d = pick_id;
                    state_d = XFER;
                end
            end
            XFER: begin
                req_ready[grant_q] = ~full;
                wr_en              = req_valid[grant_q] & ~full;
                if (wr_en && req_last[grant_q]) begin
                    state_d      = IDLE;
                    last_grant_d = grant_q;
                    frame_done_d = 1'b1;
                    if (frame_cnt_q != '1) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_grant resets to the top index so requester 0 wins first.
    always_ff @(posedge wclk or negedge wr_rstn) begin
        if (!wr_rstn) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign grant_id   = grant_q;
    assign busy       = (state_q == XFER);
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: requester queues feed beats, expected
// FIFO writes are queued in grant order and matched as wr_en fires.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic            wclk;
    logic            wr_rstn;
    logic [NR-1:0]   req_valid;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic            full;
    logic            wr_en;
    logic [DW-1:0]   wr_data;
    logic [1:0]      grant_id;
    logic            busy;
    logic            frame_done;
    logic [15:0]     frame_cnt;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .wclk       (wclk),
        .wr_rstn    (wr_rstn),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .full       (full),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .grant_id   (grant_id),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    logic [8:0]  src_q [NR][$];
    logic [15:0] exp_q [$];
    int          wlog [$];
    logic [NR-1:0] head_vld, hold, hold_n, acc;
    logic        full_n;
    int          n_chk, n_fail, cyc, done_cnt, base, dbase;

    assign req_valid = head_vld & ~hold;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic drive_phase();
        logic [8:0] h;
        full = full_n;
        hold = hold_n;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (src_q[i].size() > 0) begin
                h = src_q[i][0];
                head_vld[i]        = 1'b1;
                req_data[i*DW +: DW] = h[7:0];
                req_last[i]        = h[8];
            end else begin
                head_vld[i]        = 1'b0;
                req_data[i*DW +: DW] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    task automatic sample_phase();
        logic [15:0] e;
        acc = req_valid & req_ready;
        chk("wr_en_vs_accept", {31'b0, wr_en}, {31'b0, |acc});
        if (wr_en) begin
            wlog.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("wr_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_data", {24'b0, wr_data}, {24'b0, e[7:0]});
                chk("wr_gid", {30'b0, grant_id}, {24'b0, e[15:8]});
            end
        end
        if (frame_done) done_cnt++;
    endtask

    task automatic tick();
        @(posedge wclk);
        cyc++;
        #1;
        drive_phase();
        @(negedge wclk);
        sample_phase();
    endtask

    task automatic load_src(input int id, input logic [7:0] d0, input int n);
        for (int k = 0; k < n; k++) src_q[id].push_back({(k == n - 1), d0 + 8'(k)});
    endtask

    task automatic expect_beats(input int id, input logic [7:0] d0, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({8'(id), d0 + 8'(k)});
    endtask

    function automatic bit pending();
        bit p;
        p = (exp_q.size() != 0) || busy || (head_vld != '0);
        for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int budget);
        int t;
        t = 0;
        while (pending() && t < budget) begin
            tick();
            t++;
        end
        chk("drain_exp_left", 32'(exp_q.size()), 32'd0);
        chk("drain_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_writes(input int n, input int budget);
        int t;
        t = 0;
        while (wlog.size() < n && t < budget) begin
            tick();
            t++;
        end
        chk("wait_wr_timeout", {31'b0, (wlog.size() >= n)}, 32'd1);
    endtask

    task automatic do_reset();
        wr_rstn = 1'b0;
        for (int i = 0; i < NR; i++) src_q[i].delete();
        acc = '0;
        repeat (2) tick();
        wr_rstn = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; done_cnt = 0;
        wr_rstn = 1'b0; full = 1'b0; full_n = 1'b0; hold = '0; hold_n = '0;
        head_vld = '0; req_data = '0; req_last = '0; acc = '0;
        repeat (3) @(negedge wclk);
        wr_rstn = 1'b1;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
        chk("rst_frame_done", {31'b0, frame_done}, 32'd0);
        chk("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        chk("rst_grant_id", {30'b0, grant_id}, 32'd0);

        // two 3-beat frames on req0 and req2
        base = wlog.size();
        load_src(0, 8'h11, 3); load_src(2, 8'h21, 3);
        expect_beats(0, 8'h11, 3); expect_beats(2, 8'h21, 3);
        drain(100);
        chk("t1_frame_cnt", {16'b0, frame_cnt}, 32'd2);
        chk("t1_nwrites", 32'(wlog.size() - base), 32'd6);
        if (wlog.size() >= base + 6) begin
            chk("t1_gap01", 32'(wlog[base+1] - wlog[base]), 32'd1);
            chk("t1_gap12", 32'(wlog[base+2] - wlog[base+1]), 32'd1);
            chk("t1_gap_frames", 32'(wlog[base+3] - wlog[base+2]), 32'd2);
        end

        // single-beat frames on all requesters, req1 streaming
        do_reset();
        base = wlog.size();
        load_src(0, 8'h01, 1); load_src(0, 8'h02, 1);
        load_src(1, 8'h11, 1); load_src(1, 8'h12, 1); load_src(1, 8'h13, 1);
        load_src(2, 8'h21, 1); load_src(3, 8'h31, 1);
        expect_beats(0, 8'h01, 1); expect_beats(1, 8'h11, 1); expect_beats(2, 8'h21, 1);
        expect_beats(3, 8'h31, 1); expect_beats(0, 8'h02, 1); expect_beats(1, 8'h12, 1);
        expect_beats(1, 8'h13, 1);
        drain(100);
        chk("t2_frame_cnt", {16'b0, frame_cnt}, 32'd7);
        chk("t2_nwrites", 32'(wlog.size() - base), 32'd7);
        if (wlog.size() >= base + 7)
            for (int k = 1; k < 7; k++) chk("t2_spacing", 32'(wlog[base+k] - wlog[base+k-1]), 32'd2);

        // full held for 5 cycles mid-frame
        base = wlog.size();
        load_src(1, 8'h31, 4); expect_beats(1, 8'h31, 4);
        wait_writes(base + 1, 20);
        full_n = 1'b1;
        repeat (5) begin
            tick();
            chk("t3_full_wr_en", {31'b0, wr_en}, 32'd0);
            chk("t3_full_ready", {28'b0, req_ready}, 32'd0);
            chk("t3_full_gid", {30'b0, grant_id}, 32'd1);
            chk("t3_full_busy", {31'b0, busy}, 32'd1);
        end
        full_n = 1'b0;
        chk("t3_no_write_stalled", 32'(wlog.size() - base), 32'd1);
        drain(100);

        // owner req2 drops valid for 3 cycles while req3 waits
        base = wlog.size();
        load_src(2, 8'h41, 4); load_src(3, 8'h51, 1);
        expect_beats(2, 8'h41, 4); expect_beats(3, 8'h51, 1);
        wait_writes(base + 1, 20);
        hold_n = 4'b0100;
        repeat (3) begin
            tick();
            chk("t4_hold_wr_en", {31'b0, wr_en}, 32'd0);
            chk("t4_hold_gid", {30'b0, grant_id}, 32'd2);
            chk("t4_req3_ready", {31'b0, req_ready[3]}, 32'd0);
        end
        hold_n = '0;
        chk("t4_no_write_held", 32'(wlog.size() - base), 32'd1);
        drain(100);

        // reset during beat 2 of a 4-beat frame
        base = wlog.size();
        load_src(1, 8'h61, 4); expect_beats(1, 8'h61, 1);
        wait_writes(base + 1, 20);
        @(posedge wclk);
        cyc++;
        #1;
        drive_phase();
        #1;
        chk("t5_beat2_wr_en", {31'b0, wr_en}, 32'd1);
        wr_rstn = 1'b0;
        #1;
        chk("t5_rst_wr_en", {31'b0, wr_en}, 32'd0);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        chk("t5_rst_ready", {28'b0, req_ready}, 32'd0);
        for (int i = 0; i < NR; i++) src_q[i].delete();
        acc = '0;
        load_src(2, 8'h71, 1); load_src(3, 8'h72, 1);
        expect_beats(2, 8'h71, 1); expect_beats(3, 8'h72, 1);
        @(negedge wclk);
        sample_phase();
        tick(); tick();
        wr_rstn = 1'b1;
        #1;
        chk("t5_post_busy", {31'b0, busy}, 32'd0);
        chk("t5_post_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        drain(100);
        chk("t5_nwrites", 32'(wlog.size() - base), 32'd3);

        // frame counter saturation
        @(negedge wclk);
        force dut.frame_cnt_q = 16'hFFFE;
        #1;
        release dut.frame_cnt_q;
        #1;
        chk("t6_preset", {16'b0, frame_cnt}, 32'h0000FFFE);
        dbase = done_cnt;
        load_src(0, 8'h81, 1); load_src(1, 8'h82, 1); load_src(2, 8'h83, 1);
        expect_beats(0, 8'h81, 1); expect_beats(1, 8'h82, 1); expect_beats(2, 8'h83, 1);
        drain(100);
        chk("t6_done_pulses", 32'(done_cnt - dbase), 32'd3);
        chk("t6_frame_cnt_sat", {16'b0, frame_cnt}, 32'h0000FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
